// File: rtl/sdram_line_fetcher_if.sv
// Bundle of the fetcher's control, Avalon-MM read-master and pixel-stream signals.
// The master modport is the fetcher's view; the slave modport is the view of
// whatever drives the control inputs, the Avalon slave and the pixel sink.
interface sdram_line_fetcher_if #(
    parameter int ADDR_W = 25
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [15:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic [15:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        input  start, base_addr, avm_waitrequest, avm_readdata, avm_readdatavalid, pix_ready,
        output busy, done, avm_address, avm_read, pix_data, pix_valid
    );

    modport slave (
        output start, base_addr, avm_waitrequest, avm_readdata, avm_readdatavalid, pix_ready,
        input  busy, done, avm_address, avm_read, pix_data, pix_valid
    );
endinterface

// File: rtl/sdram_line_fetcher.sv
// Scanline fetcher: issues pipelined single-word Avalon reads for one line of
// 16-bit pixels, buffers returns in a show-ahead FIFO and streams them out.
// A read is only issued when the FIFO has room for it plus every read still in
// flight, so returned data can always be stored.
module sdram_line_fetcher #(
    parameter int ADDR_W      = 25,
    parameter int LINE_WORDS  = 640,
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_PENDING = 8
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    sdram_line_fetcher_if.master   bus
);
    localparam int CNT_W  = $clog2(LINE_WORDS + 1);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = ((FCNT_W > PEND_W) ? FCNT_W : PEND_W) + 1;

    localparam logic [CNT_W-1:0]  LINE_END  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0]  LINE_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [SUM_W-1:0]  DEPTH_S   = SUM_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [CNT_W-1:0]    issue_cnt_reg, issue_cnt_next;
    logic [CNT_W-1:0]    ret_cnt_reg, ret_cnt_next;
    logic [CNT_W-1:0]    out_cnt_reg, out_cnt_next;
    logic [PEND_W-1:0]   pending_reg, pending_next;
    logic [FCNT_W-1:0]   fifo_count_reg, fifo_count_next;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic                done_reg, done_next;

    logic [15:0]         fifo_mem [FIFO_DEPTH];

    logic                fifo_empty;
    logic                fifo_room;
    logic                accept;
    logic                ret;
    logic                pop;

    // Issue qualification: the FIFO must hold everything already buffered plus
    // everything still in flight plus this new read.
    assign fifo_empty = (fifo_count_reg == '0);
    assign fifo_room  = (SUM_W'(fifo_count_reg) + SUM_W'(pending_reg)) < DEPTH_S;

    assign bus.avm_read    = (state_reg == FETCH) && (issue_cnt_reg < LINE_END)
                             && (pending_reg < PEND_MAX) && fifo_room;
    // Counters only move on acceptance, so the address holds while stalled.
    assign bus.avm_address = base_reg + ADDR_W'({issue_cnt_reg, 1'b0});

    assign accept = bus.avm_read && !bus.avm_waitrequest;
    // Returns with nothing outstanding (stale data after reset) are discarded.
    assign ret    = bus.avm_readdatavalid && (pending_reg != '0);
    assign pop    = !fifo_empty && bus.pix_ready;

    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_reg];
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;

    // Next-state and counter update logic for the line sequencer.
    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        issue_cnt_next  = issue_cnt_reg + CNT_W'(accept);
        ret_cnt_next    = ret_cnt_reg + CNT_W'(ret);
        out_cnt_next    = out_cnt_reg + CNT_W'(pop);
        pending_next    = pending_reg + PEND_W'(accept) - PEND_W'(ret);
        fifo_count_next = fifo_count_reg + FCNT_W'(ret) - FCNT_W'(pop);
        done_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next     = FETCH;
                    base_next      = bus.base_addr & ~ADDR_W'(1);
                    issue_cnt_next = '0;
                    ret_cnt_next   = '0;
                    out_cnt_next   = '0;
                    pending_next   = '0;
                end
            end
            FETCH: begin
                if (accept && (issue_cnt_reg == LINE_LAST)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Look at next-cycle values so done lands one cycle after the last pixel.
                if ((pending_next == '0) && (fifo_count_next == '0) && (out_cnt_next == LINE_END)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state, counters and FIFO pointers with asynchronous reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            issue_cnt_reg  <= '0;
            ret_cnt_reg    <= '0;
            out_cnt_reg    <= '0;
            pending_reg    <= '0;
            fifo_count_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            issue_cnt_reg  <= issue_cnt_next;
            ret_cnt_reg    <= ret_cnt_next;
            out_cnt_reg    <= out_cnt_next;
            pending_reg    <= pending_next;
            fifo_count_reg <= fifo_count_next;
            wr_ptr_reg     <= wr_ptr_reg + PTR_W'(ret);
            rd_ptr_reg     <= rd_ptr_reg + PTR_W'(pop);
            done_reg       <= done_next;
        end
    end

    // FIFO storage: write-only clocked array, read combinationally at the head.
    always_ff @(posedge clk_clk) begin
        if (ret) begin
            fifo_mem[wr_ptr_reg] <= bus.avm_readdata;
        end
    end
endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench for sdram_line_fetcher: a latency-programmable Avalon slave model,
// a per-line reference of expected addresses/pixels, table-driven lines,
// hand-written corner sequences and randomized lines.
module tb_sdram_line_fetcher;
    localparam int ADDR_W = 25;
    localparam int LW     = 8;
    localparam int FD     = 4;
    localparam int MP     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_line_fetcher_if #(.ADDR_W(ADDR_W)) bus();

    sdram_line_fetcher #(
        .ADDR_W(ADDR_W), .LINE_WORDS(LW), .FIFO_DEPTH(FD), .MAX_PENDING(MP)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bus.master)
    );

    typedef struct {
        int        due;
        logic [15:0] data;
    } ret_t;

    typedef struct {
        logic [24:0] base;
        int          lat;
        int          ready_mode;   // 0 always ready, 1 random, 2 held low
        int          wait_mode;    // 0 none, 1 random, 2 single 5-cycle stall on 3rd read
        logic [24:0] exp_first;
        logic [24:0] exp_last;
        int          exp_done;     // cycles from start to done, 0 = not checked
    } vec_t;

    ret_t        sq[$];
    logic [24:0] exp_addr_q[$];
    logic [15:0] exp_pix_q[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int lat = 2;
    int ready_mode = 0;
    int wait_mode = 0;
    int stall_cnt = 0;
    bit stall_armed = 0;
    int stall_seen = 0;
    int accepted = 0;
    int xfers = 0;
    int inflight = 0;
    int peak_inflight = 0;
    int last_xfer_cyc = -10;
    int done_cyc = -1;
    int start_cyc = 0;
    logic [24:0] last_addr = '0;
    logic [24:0] stall_addr = '0;
    bit          prev_stall = 0;
    logic [24:0] prev_addr = '0;

    // Slave data is a fixed scramble of the word address, so each pixel identifies its source.
    function automatic logic [15:0] pix_of(input logic [24:0] a);
        return a[16:1] ^ {a[24:17], a[24:17]} ^ 16'hA55A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // One clock: observe at the falling edge, then drive the next inputs 1 time unit after the rising edge.
    task automatic step();
        ret_t r;
        @(negedge clk);
        if (bus.avm_readdatavalid && inflight > 0) inflight--;
        if (prev_stall) begin
            chk("read_hold", bus.avm_read, 1);
            chk("addr_hold", bus.avm_address, prev_addr);
        end
        if (wait_mode == 2 && bus.avm_read && bus.avm_waitrequest) begin
            chk("stall_addr", bus.avm_address, stall_addr);
            stall_seen++;
        end
        if (bus.avm_read && !bus.avm_waitrequest) begin
            accepted++;
            inflight++;
            if (inflight > peak_inflight) peak_inflight = inflight;
            if (exp_addr_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_read: got address 0x%0h, expected no read (cycle %0d)", bus.avm_address, cyc);
            end else begin
                chk("read_addr", bus.avm_address, exp_addr_q.pop_front());
            end
            chk("pending_limit", inflight <= MP, 1);
            chk("fifo_reserve", (accepted - xfers) <= FD, 1);
            last_addr = bus.avm_address;
            sq.push_back('{due: cyc + lat, data: pix_of(bus.avm_address)});
        end
        if (bus.pix_valid && bus.pix_ready) begin
            xfers++;
            last_xfer_cyc = cyc;
            if (exp_pix_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_pixel: got 0x%0h, expected no pixel (cycle %0d)", bus.pix_data, cyc);
            end else begin
                chk("pix_data", bus.pix_data, exp_pix_q.pop_front());
            end
        end
        if (bus.done) begin
            done_cyc = cyc;
            chk("done_after_last_xfer", cyc, last_xfer_cyc + 1);
            chk("busy_low_at_done", bus.busy, 0);
            chk("all_pixels_out", exp_pix_q.size(), 0);
        end
        prev_stall = bus.avm_read && bus.avm_waitrequest;
        prev_addr  = bus.avm_address;

        @(posedge clk);
        #1;
        cyc++;
        bus.start = 1'b0;
        if (sq.size() > 0 && sq[0].due <= cyc) begin
            r = sq.pop_front();
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = r.data;
        end else begin
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = 16'($urandom);
        end
        if (wait_mode == 2 && !stall_armed && accepted == 2) begin
            stall_armed = 1;
            stall_cnt   = 5;
        end
        case (wait_mode)
            1:       bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
            2: begin
                bus.avm_waitrequest = (stall_cnt > 0);
                if (stall_cnt > 0) stall_cnt--;
            end
            default: bus.avm_waitrequest = 1'b0;
        endcase
        case (ready_mode)
            1:       bus.pix_ready = ($urandom_range(0, 1) == 1);
            2:       bus.pix_ready = 1'b0;
            default: bus.pix_ready = 1'b1;
        endcase
    endtask

    // Build the expected address/pixel list for a line, then pulse start for one cycle.
    task automatic start_line(input logic [24:0] base);
        logic [24:0] a0;
        logic [24:0] a;
        a0 = base & ~25'd1;
        exp_addr_q.delete();
        exp_pix_q.delete();
        accepted = 0;
        xfers = 0;
        peak_inflight = 0;
        stall_armed = 0;
        stall_seen = 0;
        done_cyc = -1;
        for (int i = 0; i < LW; i++) begin
            a = a0 + 25'(2 * i);
            exp_addr_q.push_back(a);
            exp_pix_q.push_back(pix_of(a));
        end
        bus.base_addr = base;
        bus.start     = 1'b1;
        start_cyc     = cyc;
        step();
        chk("busy_rise", bus.busy, 1);
        chk("first_read", bus.avm_read, 1);
    endtask

    // Run until done (bounded), then check the line-level results and print one line.
    task automatic finish_line(input string name, input logic [24:0] exp_last, input int exp_done);
        int n;
        n = 0;
        while (done_cyc < 0 && n < 400) begin
            step();
            n++;
        end
        if (done_cyc < 0) begin
            n_total++;
            $display("FAIL %s_timeout: got no done in 400 cycles, expected done", name);
        end else begin
            chk("last_addr", last_addr, exp_last);
            chk("read_count", accepted, LW);
            if (exp_done != 0) chk("done_latency", done_cyc - start_cyc, exp_done);
            chk("done_one_cycle", bus.done, 0);
            chk("busy_after_done", bus.busy, 0);
        end
        $display("line %-12s base 0x%07h lat %0d reads %0d pixels %0d done_at +%0d peak_pending %0d",
                 name, bus.base_addr, lat, accepted, xfers, done_cyc - start_cyc, peak_inflight);
    endtask

    vec_t vecs[5];

    initial begin
        logic [24:0] rb;

        vecs[0] = '{25'h0000100, 2, 0, 0, 25'h0000100, 25'h000010E, 12};
        vecs[1] = '{25'h1FFFFFE, 1, 0, 0, 25'h1FFFFFE, 25'h000000C, 11};
        vecs[2] = '{25'h0000123, 6, 0, 0, 25'h0000122, 25'h0000130, 0};
        vecs[3] = '{25'h0000ABC, 2, 1, 1, 25'h0000ABC, 25'h0000ACA, 0};
        vecs[4] = '{25'h1FFFFF8, 3, 1, 0, 25'h1FFFFF8, 25'h0000006, 0};

        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = '0;
        bus.avm_readdatavalid = 1'b0;
        bus.pix_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avm_read", bus.avm_read, 0);
        chk("rst_avm_address", bus.avm_address, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;

        // Table-driven lines
        foreach (vecs[i]) begin
            lat        = vecs[i].lat;
            ready_mode = vecs[i].ready_mode;
            wait_mode  = vecs[i].wait_mode;
            start_line(vecs[i].base);
            chk("first_addr", bus.avm_address, vecs[i].exp_first);
            finish_line($sformatf("table%0d", i), vecs[i].exp_last, vecs[i].exp_done);
        end

        // Backpressure: sink stalled, only FIFO_DEPTH reads may be outstanding+buffered
        lat = 2; ready_mode = 2; wait_mode = 0;
        start_line(25'h0004000);
        repeat (20) step();
        chk("bp_reads", accepted, FD);
        chk("bp_read_low", bus.avm_read, 0);
        chk("bp_pix_valid", bus.pix_valid, 1);
        ready_mode = 0;
        finish_line("backpressure", 25'h000400E, 0);

        // Waitrequest held 5 cycles on the third read
        lat = 2; ready_mode = 0; wait_mode = 2;
        stall_addr = 25'h0000804;
        start_line(25'h0000800);
        finish_line("stall", 25'h000080E, 0);
        chk("stall_cycles", stall_seen, 5);
        wait_mode = 0;

        // start pulsed mid-line is ignored
        lat = 2; ready_mode = 0;
        start_line(25'h0001000);
        step();
        step();
        bus.start = 1'b1;
        bus.base_addr = 25'h0001500;
        step();
        finish_line("start_busy", 25'h000100E, 12);
        step();
        chk("no_restart", bus.avm_read, 0);

        // Reset asserted mid-FETCH
        start_line(25'h0000200);
        step();
        chk("pre_reset_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_avm_read", bus.avm_read, 0);
        chk("mid_rst_avm_address", bus.avm_address, 0);
        chk("mid_rst_pix_valid", bus.pix_valid, 0);
        chk("mid_rst_pix_data", bus.pix_data, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        sq.delete();
        exp_addr_q.delete();
        exp_pix_q.delete();
        inflight = 0;
        prev_stall = 0;
        bus.avm_readdatavalid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = 16'hDEAD;
        step();
        chk("stale_dropped", bus.pix_valid, 0);
        step();
        chk("stale_dropped_late", bus.pix_valid, 0);
        start_line(25'h0000300);
        finish_line("after_reset", 25'h000030E, 12);

        // Randomized lines
        for (int k = 0; k < 6; k++) begin
            rb = 25'($urandom);
            lat = $urandom_range(1, 6);
            ready_mode = 1;
            wait_mode = 1;
            start_line(rb);
            finish_line($sformatf("random%0d", k), (rb & ~25'd1) + 25'd14, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
